// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for a single-port peripheral register bus.
// Each access runs IDLE -> ACCESS (one peripheral cycle) -> RESP (one-cycle ack).
module periph_bus_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    input  logic [31:0] s_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        sel_r;
    logic        sel_nxt_s;
    logic        last_gnt_r;
    logic        last_gnt_nxt_s;
    logic        err_r;
    logic [31:0] rdata_r;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic        acc_we_s;
    logic        acc_hit_s;

    function automatic logic addr_hit(input logic [31:0] addr);
        return (addr & ADDR_MASK) == ADDR_BASE;
    endfunction

    // Next-state, grant selection and round-robin history.
    always_comb begin
        state_nxt_s    = state_r;
        sel_nxt_s      = sel_r;
        last_gnt_nxt_s = last_gnt_r;
        case (state_r)
            IDLE: begin
                if (m0_req && m1_req) begin
                    sel_nxt_s      = ~last_gnt_r;
                    last_gnt_nxt_s = ~last_gnt_r;
                    state_nxt_s    = ACCESS;
                end else if (m0_req) begin
                    sel_nxt_s      = 1'b0;
                    last_gnt_nxt_s = 1'b0;
                    state_nxt_s    = ACCESS;
                end else if (m1_req) begin
                    sel_nxt_s      = 1'b1;
                    last_gnt_nxt_s = 1'b1;
                    state_nxt_s    = ACCESS;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Granted master's request fields, straight from its held inputs.
    always_comb begin
        if (sel_r) begin
            acc_addr_s  = m1_addr;
            acc_wdata_s = m1_wdata;
            acc_we_s    = m1_we;
        end else begin
            acc_addr_s  = m0_addr;
            acc_wdata_s = m0_wdata;
            acc_we_s    = m0_we;
        end
        acc_hit_s = addr_hit(acc_addr_s);
    end

    // Peripheral bus is driven only during ACCESS; misses never strobe a write.
    always_comb begin
        s_addr_o = 32'd0;
        s_data_o = 32'd0;
        s_we_o   = 1'b0;
        if (state_r == ACCESS) begin
            s_addr_o = acc_addr_s;
            s_data_o = acc_wdata_s;
            s_we_o   = acc_hit_s & acc_we_s;
        end else begin
            s_we_o   = 1'b0;
        end
    end

    // Response is steered to the selected master only, from registered data.
    always_comb begin
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = 32'd0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = 32'd0;
        if (state_r == RESP) begin
            if (sel_r) begin
                m1_ack   = 1'b1;
                m1_err   = err_r;
                m1_rdata = rdata_r;
            end else begin
                m0_ack   = 1'b1;
                m0_err   = err_r;
                m0_rdata = rdata_r;
            end
        end else begin
            m0_ack = 1'b0;
            m1_ack = 1'b0;
        end
    end

    // State registers; read data is frozen at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= 1'b0;
            last_gnt_r <= 1'b1;
            err_r      <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            sel_r      <= sel_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            if (state_r == ACCESS) begin
                rdata_r <= acc_hit_s ? s_data_i : 32'd0;
                err_r   <= ~acc_hit_s;
            end else begin
                rdata_r <= rdata_r;
                err_r   <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_periph_bus_arbiter;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_we_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_data_i(s_data_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a & MASK) == BASE;
    endfunction

    // Transaction-level model: one access at a time, granted at edge g,
    // peripheral cycle right after g, acknowledge one cycle later, next grant at g+3.
    int          k = 0;
    int          free_edge = 0;
    int          last_w = 1;
    bit          tv = 1'b0;
    int          tw, tg;
    logic [31:0] ta, td, trd;
    logic        twe, terr;

    always @(posedge clk) begin
        k++;
        if (rst) begin
            tv        = 1'b0;
            last_w    = 1;
            free_edge = k + 1;
        end else begin
            if (tv && k == tg + 1) begin
                trd  = in_window(ta) ? s_data_i : 32'd0;
                terr = !in_window(ta);
            end
            if (k >= free_edge && (m0_req || m1_req)) begin
                tw        = (m0_req && m1_req) ? 1 - last_w : (m0_req ? 0 : 1);
                last_w    = tw;
                tv        = 1'b1;
                tg        = k;
                free_edge = k + 3;
                ta        = (tw == 1) ? m1_addr  : m0_addr;
                td        = (tw == 1) ? m1_wdata : m0_wdata;
                twe       = (tw == 1) ? m1_we    : m0_we;
            end
        end
    end

    logic [31:0] e_saddr, e_sdata, e_rd0, e_rd1;
    logic        e_swe, e_ack0, e_err0, e_ack1, e_err1;

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (k > 0) begin
            e_saddr = 32'd0; e_sdata = 32'd0; e_swe = 1'b0;
            e_ack0 = 1'b0; e_err0 = 1'b0; e_rd0 = 32'd0;
            e_ack1 = 1'b0; e_err1 = 1'b0; e_rd1 = 32'd0;
            if (tv && k == tg) begin
                e_saddr = ta;
                e_sdata = td;
                e_swe   = twe && in_window(ta);
            end
            if (tv && k == tg + 1) begin
                if (tw == 0) begin e_ack0 = 1'b1; e_err0 = terr; e_rd0 = trd; end
                else         begin e_ack1 = 1'b1; e_err1 = terr; e_rd1 = trd; end
            end
            chk("mdl_s_addr", s_addr_o, e_saddr);
            chk("mdl_s_data", s_data_o, e_sdata);
            chk("mdl_s_we",   32'(s_we_o), 32'(e_swe));
            chk("mdl_m0_resp", {29'd0, m0_ack, m0_err, 1'b0}, {29'd0, e_ack0, e_err0, 1'b0});
            chk("mdl_m0_rdata", m0_rdata, e_rd0);
            chk("mdl_m1_resp", {29'd0, m1_ack, m1_err, 1'b0}, {29'd0, e_ack1, e_err1, 1'b0});
            chk("mdl_m1_rdata", m1_rdata, e_rd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return BASE + 32'($urandom_range(0, 15));
    endfunction

    int  seq[$];
    bit  a0, a1;

    initial begin
        rst = 1'b1; s_data_i = 32'd0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        tick(); tick();
        @(negedge clk);
        chk("rst_flags", {27'd0, m0_ack, m0_err, m1_ack, m1_err, s_we_o}, 32'd0);
        chk("rst_data", m0_rdata | m1_rdata | s_addr_o | s_data_o, 32'd0);

        // Single M0 write.
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2000_0008; m0_wdata = 32'h0000_0010;
        tick();
        @(negedge clk);
        chk("wr_s_we", 32'(s_we_o), 32'd1);
        chk("wr_s_addr", s_addr_o, 32'h2000_0008);
        chk("wr_s_data", s_data_o, 32'h0000_0010);
        tick();
        @(negedge clk);
        chk("wr_ack_err", {30'd0, m0_ack, m0_err}, 32'd2);
        chk("wr_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("wr_we_off", 32'(s_we_o), 32'd0);

        // Single M1 read; peripheral value changes during RESP.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000_0004; s_data_i = 32'h0000_0007;
        tick();
        @(negedge clk);
        chk("rd_s_we", 32'(s_we_o), 32'd0);
        tick();
        s_data_i = 32'h0000_0008;
        @(negedge clk);
        chk("rd_ack_err", {30'd0, m1_ack, m1_err}, 32'd2);
        chk("rd_rdata", m1_rdata, 32'h0000_0007);
        tick();
        m1_req = 1'b0;

        // Tie straight after reset: M0 first, M1 three cycles later.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = BASE;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = BASE + 32'd4;
        s_data_i = 32'h0000_0011;
        tick(); tick();
        s_data_i = 32'h0000_0022;
        @(negedge clk);
        chk("tie_first", {30'd0, m0_ack, m1_ack}, 32'd2);
        chk("tie_rdata0", m0_rdata, 32'h0000_0011);
        tick();
        m0_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("tie_second", {30'd0, m0_ack, m1_ack}, 32'd1);
        chk("tie_rdata1", m1_rdata, 32'h0000_0022);

        // Continuous contention: grants must alternate starting with M0.
        tick();
        m0_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            s_data_i = $urandom;
            @(negedge clk);
            if (m0_ack) seq.push_back(0);
            if (m1_ack) seq.push_back(1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_count", 32'(seq.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++)
            chk("rr_order", (i < seq.size()) ? 32'(seq[i]) : 32'd9, 32'(i % 2));
        tick(); tick(); tick();

        // Out-of-window write.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h3000_0000; m0_wdata = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        chk("oow_s_we", 32'(s_we_o), 32'd0);
        tick();
        @(negedge clk);
        chk("oow_ack_err", {30'd0, m0_ack, m0_err}, 32'd3);
        chk("oow_rdata", m0_rdata, 32'd0);
        tick();
        m0_req = 1'b0;

        // Reset during the ACCESS cycle of an M1 read, then a clean retry.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = BASE + 32'hC; s_data_i = 32'h0000_0055;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_flags", {27'd0, m0_ack, m0_err, m1_ack, m1_err, s_we_o}, 32'd0);
        chk("rst_mid_data", m1_rdata | s_addr_o, 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("retry_ack", 32'(m1_ack), 32'd1);
        chk("retry_rdata", m1_rdata, 32'h0000_0055);
        tick();
        m1_req = 1'b0;

        // Randomized traffic with abandoned requests and occasional resets.
        a0 = 1'b0; a1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst      = ($urandom_range(0, 99) == 0);
            s_data_i = $urandom;
            if (a0 || !m0_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    m0_req = 1'b1; m0_we = 1'($urandom); m0_addr = rand_addr(); m0_wdata = $urandom;
                end else m0_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) m0_req = 1'b0;
            if (a1 || !m1_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    m1_req = 1'b1; m1_we = 1'($urandom); m1_addr = rand_addr(); m1_wdata = $urandom;
                end else m1_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) m1_req = 1'b0;
            @(negedge clk);
            a0 = m0_ack;
            a1 = m1_ack;
        end

        tick();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
